// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin grant controller.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Requester index to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_prio_enc8.sv
// Round-robin priority encoder: first set request at or above ptr, wrapping 7->0.
module rr_prio_enc8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   sel
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    // Rotate so that requester ptr lands on bit 0, encode, then undo the rotation.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        any = |req;
        sel = off + ptr;
    end

endmodule

// File: rtl/rr_grant_ctrl8.sv
// Round-robin grant controller: one owner at a time, bounded tenure, one idle cycle between grants.
module rr_grant_ctrl8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic             enc_any;
    logic [IDX_W-1:0] enc_sel;
    logic             owner_req;
    logic             at_limit;
    logic             rel;
    logic             forced;

    rr_prio_enc8 u_enc (
        .req (req),
        .ptr (ptr),
        .any (enc_any),
        .sel (enc_sel)
    );

    // Release decode; timeout only when the hold limit is the sole cause.
    always_comb begin
        owner_req = req[gnt_idx];
        at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        rel       = done || !owner_req || at_limit;
        forced    = at_limit && !done && owner_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        gnt      <= onehot(enc_sel);
                        gnt_idx  <= enc_sel;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        gnt      <= '0;
                        gnt_idx  <= '0;
                        gnt_vld  <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= gnt_idx + IDX_W'(1);
                        timeout  <= forced;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Scoreboard bench for rr_grant_ctrl8 with MAX_HOLD=4.
module tb_rr_grant_ctrl8;

    localparam int M_DONE = 0;
    localparam int M_TO   = 1;
    localparam int M_DROP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    typedef struct {
        int idx;
        int len;
        bit to;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    bit   prev_vld = 1'b0;
    bit   active   = 1'b0;
    int   cnt      = 0;

    rr_grant_ctrl8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on each new grant, checks tenure length and timeout at release.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
            active   = 1'b0;
        end else begin
            check("inv_gnt", 32'(gnt), gnt_vld ? 32'(8'b1 << gnt_idx) : 32'h0);
            if (!gnt_vld) check("idle_idx", 32'(gnt_idx), 32'h0);
            if (gnt_vld && !prev_vld) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got idx %0d expected none at %0t", gnt_idx, $time);
                end else begin
                    cur    = q.pop_front();
                    active = 1'b1;
                    cnt    = 1;
                    check("grant_idx", 32'(gnt_idx), 32'(cur.idx));
                    check("grant_vec", 32'(gnt), 32'(1) << cur.idx);
                end
            end else if (gnt_vld) begin
                cnt++;
            end
            if (prev_vld && !gnt_vld && active) begin
                check("tenure_len", 32'(cnt), 32'(cur.len));
                check("timeout_pulse", 32'(timeout), 32'(cur.to));
                active = 1'b0;
            end else begin
                check("timeout_idle", 32'(timeout), 32'h0);
            end
            prev_vld = gnt_vld;
        end
    end

    // Queue one expected tenure, wait for the grant, then end it by done, req drop or hold limit.
    task automatic serve(input int idx, input int cycles, input int mode);
        exp_t e;
        int   n;
        e.idx = idx;
        e.len = cycles;
        e.to  = (mode == M_TO);
        q.push_back(e);
        n = 0;
        while (!gnt_vld && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!gnt_vld) begin
            checks++;
            failures++;
            $display("FAIL grant_wait: got no grant expected idx %0d at %0t", idx, $time);
            return;
        end
        repeat (cycles - 1) begin
            @(posedge clk);
            #1;
        end
        if (mode == M_DONE) done = 1'b1;
        else if (mode == M_DROP) req[idx] = 1'b0;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000 at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_vld", 32'(gnt_vld), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_vld", 32'(gnt_vld), 32'h0);
        check("post_rst_idx", 32'(gnt_idx), 32'h0);

        // Single requester: done ends first tenure, regrant after gap, then req drop.
        req = 8'h10;
        serve(4, 3, M_DONE);
        serve(4, 2, M_DROP);

        // Hold limit: forced release, then done coinciding with the limit.
        req = 8'h04;
        serve(2, 4, M_TO);
        serve(2, 4, M_DONE);
        req = 8'h00;

        // done while idle must not grant.
        done = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        done = 1'b0;
        check("idle_done_vld", 32'(gnt_vld), 32'h0);

        // Asynchronous reset in the middle of a tenure.
        req = 8'h20;
        n = 0;
        while (!gnt_vld && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_gnt", 32'(gnt), 32'h20);
        check("mid_idx", 32'(gnt_idx), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_idx", 32'(gnt_idx), 32'h0);
        check("async_vld", 32'(gnt_vld), 32'h0);
        req = 8'h00;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full rotation from ptr=0.
        req = 8'hFF;
        for (int i = 0; i < 9; i++) serve(i % 8, 2, M_DONE);
        req = 8'h00;

        // Wrap-around: serve 6 so ptr=7, then 7 before 0.
        req = 8'h40;
        serve(6, 1, M_DROP);
        req = 8'h81;
        serve(7, 2, M_DONE);
        serve(0, 2, M_DONE);
        req = 8'h00;

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("queue_empty", 32'(q.size()), 32'h0);
        check("no_open_tenure", 32'(active), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl8.md
Name: rr_grant_ctrl8

Overview:
- Sequential round-robin arbiter that shares one 8-input priority-encode resource between 8 requesters.
- Grants one requester at a time and holds the grant for a bounded tenure.
- Presents the winner as a one-hot vector and as a 3-bit encoded index to downstream logic.
- Sits between the requester bank and the shared datapath; the index drives the datapath select.

Parameters:
- MAX_HOLD, 8, maximum tenure in cycles before forced release (legal range 1..255).
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width (derived; not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request per requester; bit k = requester k.
- done  input  1  pulse from the current owner ending its tenure; ignored unless a grant is valid.
- gnt  output  8  one-hot grant; all zeros when no grant.
- gnt_idx  output  3  encoded index of gnt (k for gnt[k]); 0 when no grant.
- gnt_vld  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a tenure is force-released by MAX_HOLD.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE.
- Reset asserted mid-tenure drops all outputs immediately, without waiting for a clock edge.
- All outputs are registered; there is no combinational path from req or done to any output.
- State IDLE:
  - If req != 0, select the first set bit searching from ptr upward, wrapping 7->0.
  - On the next edge: gnt=onehot(sel), gnt_idx=sel, gnt_vld=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled high in IDLE to gnt_vld=1 is 1 cycle.
  - If req == 0, stay in IDLE with outputs at their reset values.
- State GRANT, evaluated each edge with owner=gnt_idx:
  - Release condition: done=1, or req[owner]=0, or hold_cnt==MAX_HOLD-1.
  - Otherwise hold_cnt increments and the grant is unchanged.
  - On release: gnt=0, gnt_idx=0, gnt_vld=0, ptr=owner+1 mod 8 (7 wraps to 0), state=IDLE.
  - timeout=1 for exactly the release cycle only when the sole cause is hold_cnt==MAX_HOLD-1.
  - If done or a req drop coincides with the limit, the release is normal and timeout stays 0.
- Mandatory gap: every release is followed by at least one cycle with gnt_vld=0 (IDLE) before the next grant. Back-to-back grants are therefore separated by exactly one idle cycle.
- Fairness: a continuously requesting requester waits at most 7 tenures.
- Request changes on non-owner bits during GRANT have no effect until the next IDLE.
- done is ignored in IDLE.
- Invariants: gnt_vld=1 implies gnt has exactly one bit set and gnt==1<<gnt_idx; gnt_vld=0 implies gnt==0.
- MAX_HOLD=1: every tenure is exactly 1 cycle, and timeout fires unless done or a req drop occurs in that cycle.

Decomposition:
- Shared package arb_pkg holds:
  - NUM_REQ=8 and IDX_W=3.
  - State enum {IDLE, GRANT}.
  - Function onehot(idx).
- One combinational sub-module, rr_prio_enc8:
  - Inputs req[7:0] and ptr[2:0].
  - Outputs any (1 bit) and sel[2:0].
  - Implemented as rotate-by-ptr, fixed 8-to-3 priority encode, add ptr back mod 8.
- The controller instantiates rr_prio_enc8 once and owns all registers.

Test Plan:
- Reset check: rst_n=0 then release with req=8'h00 -> gnt=0, gnt_idx=0, gnt_vld=0 for 5 cycles; drop rst_n mid-tenure -> outputs go to 0 without a clock edge.
- Single request: req=8'h10 held, done pulsed 3 cycles after grant -> gnt=8'h10 and gnt_idx=4 one cycle after req; release, one idle cycle, then regrant of requester 4 with ptr=5.
- Rotation: req=8'hFF held, each owner pulses done after 2 cycles -> grant order 0,1,2,...,7,0, each separated by one gnt_vld=0 cycle.
- Wrap-around: ptr=7 (after serving requester 6), req=8'h81 -> requester 7 is granted first, then requester 0.
- Timeout: MAX_HOLD=4, req=8'h04 held with no done -> gnt_vld high for exactly 4 cycles, then timeout=1 for 1 cycle.
- Simultaneous events: done=1 in the cycle where hold_cnt==MAX_HOLD-1 -> release with timeout=0; req[owner] drops mid-tenure -> release on the next edge.
